// File: rtl/vend_pkg.sv
// Shared types and width helpers for the vending transaction path.
// Also used by the item memory for its address width.
package vend_pkg;

  localparam int CUR_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Idle counter runs 0..t-1.
  function automatic int tmo_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Bundle between the transaction controller, the front panel
// and the item memory read/dispense port.
interface vend_txn_ctrl_if
  import vend_pkg::*;
#(
  parameter int AW    = addr_w(1024),
  parameter int CUR_W = CUR_W_DEF
);
  logic             cfg_mode;
  logic             sel_valid;
  logic [AW-1:0]    sel_index;
  logic             sel_ready;
  logic             coin_valid;
  logic [CUR_W-1:0] coin_value;
  logic             coin_ready;
  logic             cancel;
  logic [AW-1:0]    mem_raddr;
  logic [CUR_W-1:0] mem_price;
  logic [7:0]       mem_avail;
  logic             dispense_valid;
  logic [AW-1:0]    dispense_index;
  logic             change_valid;
  logic [CUR_W-1:0] change_amount;
  logic             sold_out;
  logic [CUR_W-1:0] credit;
  logic             busy;

  modport master (
    output cfg_mode, sel_valid, sel_index,
    output coin_valid, coin_value, cancel,
    output mem_price, mem_avail,
    input  sel_ready, coin_ready, mem_raddr,
    input  dispense_valid, dispense_index,
    input  change_valid, change_amount,
    input  sold_out, credit, busy
  );

  modport slave (
    input  cfg_mode, sel_valid, sel_index,
    input  coin_valid, coin_value, cancel,
    input  mem_price, mem_avail,
    output sel_ready, coin_ready, mem_raddr,
    output dispense_valid, dispense_index,
    output change_valid, change_amount,
    output sold_out, credit, busy
  );

endinterface

// File: rtl/vend_credit_acc.sv
// Saturating credit register, coin acceptance and the
// COLLECT idle timeout counter.
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int CUR_W       = CUR_W_DEF,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             coin_valid,
  input  logic [CUR_W-1:0] coin_value,
  input  logic             coin_ready,
  input  logic             clr,
  input  logic             tmo_clr,
  output logic             coin_acc,
  output logic [CUR_W-1:0] credit,
  output logic [CUR_W-1:0] credit_nxt,
  output logic             tmo_hit
);

  localparam int TW = tmo_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYC - 1);

  logic [CUR_W:0]  sum;
  logic [TW-1:0]   tmo_cnt;

  assign coin_acc = coin_valid && coin_ready;
  assign sum = {1'b0, credit} + {1'b0, coin_value};
  assign tmo_hit = (tmo_cnt == TMO_LAST) && !coin_acc;

  always_comb begin
    credit_nxt = credit;
    unique case (1'b1)
      clr:      credit_nxt = '0;
      coin_acc: credit_nxt = sum[CUR_W] ? '1
                                        : sum[CUR_W-1:0];
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      credit  <= '0;
      tmo_cnt <= '0;
    end else begin
      credit <= credit_nxt;
      if (tmo_clr || coin_acc)
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction FSM: selection lookup, credit collection,
// dispense update to the item memory and change return.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_ITEMS   = 1024,
  parameter int CUR_W       = CUR_W_DEF,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          rstn,
  vend_txn_ctrl_if.slave bus
);

  localparam int AW = addr_w(MAX_ITEMS);

  state_t           state, state_d;
  logic             lk_cnt;
  logic [AW-1:0]    sel_q;
  logic [CUR_W-1:0] price_q;
  logic [CUR_W-1:0] credit, credit_nxt;
  logic [CUR_W-1:0] chg_amt, amt_d;
  logic             coin_ready, coin_acc, tmo_hit;
  logic             sel_ready, sel_go, lk_done;
  logic             chg_go, sold_q, chg_q;

  assign sel_ready  = (state == S_IDLE) && !bus.cfg_mode;
  assign coin_ready = (state != S_CHANGE);
  assign sel_go     = bus.sel_valid && sel_ready;
  assign lk_done    = (state == S_LOOKUP) && lk_cnt;

  vend_credit_acc #(
    .CUR_W       (CUR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_acc (
    .clk        (clk),
    .rstn       (rstn),
    .coin_valid (bus.coin_valid),
    .coin_value (bus.coin_value),
    .coin_ready (coin_ready),
    .clr        (state == S_CHANGE),
    .tmo_clr    (state != S_COLLECT),
    .coin_acc   (coin_acc),
    .credit     (credit),
    .credit_nxt (credit_nxt),
    .tmo_hit    (tmo_hit)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (sel_go)
          state_d = S_LOOKUP;
        else if (bus.cancel && credit != '0)
          state_d = S_CHANGE;
      end
      S_LOOKUP: begin
        if (lk_cnt)
          state_d = (bus.mem_avail == '0) ? S_CHANGE
                                          : S_COLLECT;
      end
      S_COLLECT: begin
        if (credit >= price_q)
          state_d = S_DISPENSE;
        else if (bus.cancel || tmo_hit)
          state_d = S_CHANGE;
      end
      S_DISPENSE: begin
        // a concurrent config write would mask the update
        if (!bus.cfg_mode)
          state_d = S_CHANGE;
      end
      S_CHANGE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Coins landing in the same edge are part of the change.
  assign chg_go = (state_d == S_CHANGE) && (state != S_CHANGE);
  assign amt_d  = (state == S_DISPENSE) ? credit_nxt - price_q
                                        : credit_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      lk_cnt  <= 1'b0;
      sel_q   <= '0;
      price_q <= '0;
      sold_q  <= 1'b0;
      chg_q   <= 1'b0;
      chg_amt <= '0;
    end else begin
      state  <= state_d;
      lk_cnt <= (state == S_LOOKUP) && !lk_cnt;
      if (sel_go)
        sel_q <= bus.sel_index;
      if (lk_done)
        price_q <= bus.mem_price;
      sold_q <= lk_done && (bus.mem_avail == '0);
      chg_q  <= chg_go && (amt_d != '0);
      if (chg_go && amt_d != '0)
        chg_amt <= amt_d;
    end
  end

  assign bus.sel_ready      = sel_ready;
  assign bus.coin_ready     = coin_ready;
  assign bus.mem_raddr      = sel_q;
  assign bus.dispense_valid = (state == S_DISPENSE)
                              && !bus.cfg_mode;
  assign bus.dispense_index = sel_q;
  assign bus.change_valid   = chg_q;
  assign bus.change_amount  = chg_amt;
  assign bus.sold_out       = sold_q;
  assign bus.credit         = credit;
  assign bus.busy           = (state != S_IDLE);

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed and randomized checks of vend_txn_ctrl against a
// transaction-level model and a small item memory model.
module tb_vend_txn_ctrl;

  localparam int NI  = 16;
  localparam int AW  = 4;
  localparam int CW  = 16;
  localparam int TMO = 20;

  logic clk;
  logic rstn;

  vend_txn_ctrl_if #(.AW(AW), .CUR_W(CW)) bus ();

  vend_txn_ctrl #(
    .MAX_ITEMS   (NI),
    .CUR_W       (CW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // item memory: registered read, write port, saturating decrement
  logic          we;
  logic [AW-1:0] wa;
  logic [CW-1:0] wp;
  logic [7:0]    ws;
  logic [CW-1:0] pm [NI];
  logic [7:0]    am [NI];

  always @(posedge clk) begin
    bus.mem_price <= pm[bus.mem_raddr];
    bus.mem_avail <= am[bus.mem_raddr];
    if (we) begin
      pm[wa] <= wp;
      am[wa] <= ws;
    end else if (bus.dispense_valid &&
                 am[bus.dispense_index] != 8'd0) begin
      am[bus.dispense_index] <= am[bus.dispense_index] - 8'd1;
    end
  end

  int n_disp, n_chg, n_sold;
  logic [31:0] disp_idx, chg_seen;

  initial begin
    n_disp = 0; n_chg = 0; n_sold = 0;
    disp_idx = 0; chg_seen = 0;
  end

  always @(negedge clk) begin
    if (bus.dispense_valid) begin
      n_disp++;
      disp_idx = 32'(bus.dispense_index);
    end
    if (bus.change_valid) begin
      n_chg++;
      chg_seen = 32'(bus.change_amount);
    end
    if (bus.sold_out) n_sold++;
  end

  int tests, fails;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    bus.coin_value = CW'(v);
    bus.coin_valid = 1'b1;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic sel(input int s);
    bus.sel_index = AW'(s);
    bus.sel_valid = 1'b1;
    tick();
    bus.sel_valid = 1'b0;
  endtask

  task automatic cancel_pulse();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  task automatic mem_wr(input int a, input int p, input int s);
    bus.cfg_mode = 1'b1;
    wa = AW'(a); wp = CW'(p); ws = 8'(s); we = 1'b1;
    tick();
    we = 1'b0;
    bus.cfg_mode = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  function automatic int sat16(input int a);
    return (a > 65535) ? 65535 : a;
  endfunction

  function automatic int pick_coin();
    case ($urandom_range(0, 4))
      0: return 5;
      1: return 10;
      2: return 25;
      3: return 50;
      default: return 100;
    endcase
  endfunction

  int ref_price [NI];
  int ref_avail [NI];
  int d0, c0, s0, wcnt;
  int c, s, v, p, a;
  int exp_chg;
  bit exp_disp, exp_sold, done;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    we = 0; wa = '0; wp = '0; ws = '0;
    bus.cfg_mode = 0; bus.sel_valid = 0; bus.sel_index = '0;
    bus.coin_valid = 0; bus.coin_value = '0; bus.cancel = 0;

    // reset with a coin strobe held high
    rstn = 1'b0;
    bus.coin_valid = 1'b1;
    bus.coin_value = CW'(55);
    tick(); tick();
    @(negedge clk);
    chk("rst_credit", 32'(bus.credit), 32'd0);
    chk("rst_sold", 32'(bus.sold_out), 32'd0);
    chk("rst_disp", 32'(bus.dispense_valid), 32'd0);
    chk("rst_chg", 32'(bus.change_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_raddr", 32'(bus.mem_raddr), 32'd0);
    chk("rst_didx", 32'(bus.dispense_index), 32'd0);
    chk("rst_amt", 32'(bus.change_amount), 32'd0);
    bus.coin_valid = 1'b0;
    rstn = 1'b1;
    tick();
    chk("rst_sel_ready", 32'(bus.sel_ready), 32'd1);

    mem_wr(5, 150, 3);
    mem_wr(7, 80, 0);
    mem_wr(9, 200, 2);
    mem_wr(11, 0, 2);

    // pre-paid dispense with exact edge timing
    coin(100); coin(100);
    sel(5);
    @(negedge clk);
    chk("lk_raddr", 32'(bus.mem_raddr), 32'd5);
    chk("lk_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("col_nodisp", 32'(bus.dispense_valid), 32'd0);
    @(negedge clk);
    chk("e3_disp", 32'(bus.dispense_valid), 32'd1);
    chk("e3_didx", 32'(bus.dispense_index), 32'd5);
    @(negedge clk);
    chk("e4_chg", 32'(bus.change_valid), 32'd1);
    chk("e4_amt", 32'(bus.change_amount), 32'd50);
    chk("e4_nodisp", 32'(bus.dispense_valid), 32'd0);
    @(negedge clk);
    chk("e5_busy", 32'(bus.busy), 32'd0);
    chk("e5_credit", 32'(bus.credit), 32'd0);
    chk("e5_chg_low", 32'(bus.change_valid), 32'd0);
    chk("e5_amt_held", 32'(bus.change_amount), 32'd50);

    // sold out slot refunds the pre-inserted coin
    d0 = n_disp;
    coin(25);
    sel(7);
    @(negedge clk);
    @(negedge clk);
    chk("so_early", 32'(bus.sold_out), 32'd0);
    @(negedge clk);
    chk("so_pulse", 32'(bus.sold_out), 32'd1);
    chk("so_chg", 32'(bus.change_valid), 32'd1);
    chk("so_amt", 32'(bus.change_amount), 32'd25);
    @(negedge clk);
    chk("so_idle", 32'(bus.busy), 32'd0);
    chk("so_single", 32'(bus.sold_out), 32'd0);
    chk("so_nodisp", 32'(n_disp), 32'(d0));

    // idle timeout refund
    d0 = n_disp;
    sel(9);
    tick(); tick();
    coin(50);
    wcnt = 0;
    @(negedge clk);
    while (!bus.change_valid && wcnt < TMO + 20) begin
      @(negedge clk);
      wcnt++;
    end
    chk("tmo_pulse", 32'(bus.change_valid), 32'd1);
    chk("tmo_cycles", 32'(wcnt), 32'(TMO));
    chk("tmo_amt", 32'(bus.change_amount), 32'd50);
    @(negedge clk);
    chk("tmo_idle", 32'(bus.busy), 32'd0);
    chk("tmo_nodisp", 32'(n_disp), 32'(d0));

    // saturation, then refund from IDLE
    coin(16'hFFF0);
    coin(16'h0100);
    @(negedge clk);
    chk("sat_credit", 32'(bus.credit), 32'hFFFF);
    tick();
    cancel_pulse();
    @(negedge clk);
    chk("idle_cancel_chg", 32'(bus.change_valid), 32'd1);
    chk("idle_cancel_amt", 32'(bus.change_amount), 32'hFFFF);
    @(negedge clk);
    chk("idle_cancel_clr", 32'(bus.credit), 32'd0);

    // cancel with zero credit is ignored
    tick();
    cancel_pulse();
    @(negedge clk);
    chk("zero_cancel", 32'(bus.busy), 32'd0);

    // coin and cancel in the same COLLECT cycle
    tick();
    coin(30);
    sel(9);
    tick(); tick();
    bus.coin_value = CW'(40);
    bus.coin_valid = 1'b1;
    bus.cancel = 1'b1;
    tick();
    bus.coin_valid = 1'b0;
    bus.cancel = 1'b0;
    @(negedge clk);
    chk("cc_chg", 32'(bus.change_valid), 32'd1);
    chk("cc_amt", 32'(bus.change_amount), 32'd70);

    // cfg_mode holds the dispense update
    tick();
    coin(100); coin(100);
    sel(5);
    tick(); tick();
    bus.cfg_mode = 1'b1;
    d0 = n_disp;
    c0 = n_chg;
    repeat (4) @(negedge clk);
    chk("cfg_held", 32'(n_disp), 32'(d0));
    chk("cfg_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.cfg_mode = 1'b0;
    wait_idle();
    chk("cfg_one_pulse", 32'(n_disp), 32'(d0 + 1));
    chk("cfg_chg_amt", chg_seen, 32'd50);
    chk("cfg_chg_cnt", 32'(n_chg), 32'(c0 + 1));

    // price 0 dispenses for free
    tick();
    d0 = n_disp;
    c0 = n_chg;
    sel(11);
    wait_idle();
    chk("free_disp", 32'(n_disp), 32'(d0 + 1));
    chk("free_nochg", 32'(n_chg), 32'(c0));
    tick();
    coin(10);
    sel(11);
    wait_idle();
    chk("free_disp2", 32'(n_disp), 32'(d0 + 2));
    chk("free_chg", chg_seen, 32'd10);

    // reset mid-transaction discards credit silently
    tick();
    coin(50);
    sel(9);
    tick(); tick();
    c0 = n_chg;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_nochg", 32'(n_chg), 32'(c0));
    chk("mrst_credit", 32'(bus.credit), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);

    // randomized transactions
    tick();
    for (int i = 0; i < NI; i++) begin
      p = 5 * $urandom_range(0, 60);
      a = $urandom_range(0, 3);
      mem_wr(i, p, a);
      ref_price[i] = p;
      ref_avail[i] = a;
    end
    for (int t = 0; t < 40; t++) begin
      s = $urandom_range(0, NI - 1);
      c = 0;
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        v = pick_coin();
        coin(v);
        c = sat16(c + v);
      end
      d0 = n_disp; c0 = n_chg; s0 = n_sold;
      sel(s);
      tick(); tick();
      exp_sold = (ref_avail[s] == 0);
      exp_disp = 0;
      exp_chg = c;
      done = exp_sold;
      for (int g = 0; g < 12 && !done; g++) begin
        if (c >= ref_price[s]) begin
          exp_disp = 1;
          exp_chg = c - ref_price[s];
          done = 1;
        end else if ($urandom_range(0, 4) == 0) begin
          cancel_pulse();
          exp_chg = c;
          done = 1;
        end else begin
          v = pick_coin();
          coin(v);
          c = sat16(c + v);
          tick(); tick();
        end
      end
      if (!done) begin
        if (c >= ref_price[s]) begin
          exp_disp = 1;
          exp_chg = c - ref_price[s];
        end else begin
          cancel_pulse();
          exp_chg = c;
        end
      end
      wait_idle();
      if (exp_disp) ref_avail[s]--;
      chk("rnd_disp", 32'(n_disp - d0), 32'(exp_disp));
      if (exp_disp)
        chk("rnd_didx", disp_idx, 32'(s));
      chk("rnd_sold", 32'(n_sold - s0), 32'(exp_sold));
      chk("rnd_chg_cnt", 32'(n_chg - c0),
          32'(exp_chg != 0));
      if (exp_chg != 0)
        chk("rnd_chg_amt", chg_seen, 32'(exp_chg));
      chk("rnd_credit", 32'(bus.credit), 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction controller for the vending datapath. It accepts an item selection and coin inserts, reads price and stock for the selected slot from the item memory through its registered 1-cycle read port, and accumulates credit. When the credit covers the price it issues the one-cycle dispense update to the item memory and returns any change. It sits directly upstream of the item memory and owns its read address and dispense-update inputs.

## Interface
Parameters:
- MAX_ITEMS, 1024, slot count; AW = $clog2(MAX_ITEMS)
- CUR_W, 16, currency/credit width; matches item price width
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before auto-refund; minimum 1

Ports:
- clk  in  1  sole clock; all state on posedge
- rstn  in  1  one clock; reset is synchronous and active-low
- cfg_mode  in  1  configuration writes to item memory in progress
- sel_valid  in  1  item selection strobe
- sel_index  in  AW  selected slot
- sel_ready  out  1  = (state==IDLE) && !cfg_mode
- coin_valid  in  1  coin strobe
- coin_value  in  CUR_W  coin value
- coin_ready  out  1  = (state!=CHANGE)
- cancel  in  1  refund request
- mem_raddr  out  AW  item memory read address
- mem_price  in  CUR_W  item memory price, valid 1 cycle after raddr is sampled
- mem_avail  in  8  item memory stock count
- dispense_valid  out  1  one-cycle dispense update pulse
- dispense_index  out  AW  slot for dispense update
- change_valid  out  1  one-cycle change pulse
- change_amount  out  CUR_W  change value, held until next pulse
- sold_out  out  1  one-cycle pulse: selected slot has zero stock
- credit  out  CUR_W  current accumulated credit
- busy  out  1  state!=IDLE

## Operation
- States: IDLE, LOOKUP, COLLECT, DISPENSE, CHANGE. A 1-bit lookup counter runs within LOOKUP.
- IDLE: on sel_valid&&sel_ready, register sel_index into mem_raddr and the selection register, then go to LOOKUP. Selections are ignored when not ready.
- LOOKUP: two cycles. At the end of the second cycle, latch mem_price/mem_avail. If avail==0, pulse sold_out, then go to CHANGE (full refund). Otherwise go to COLLECT.
- COLLECT: if credit>=latched price, go to DISPENSE. cancel goes to CHANGE with a full refund. Timeout counter resets on each accepted coin. On reaching TIMEOUT_CYC, behave as cancel.
- DISPENSE: assert dispense_valid with dispense_index = selection for exactly one cycle, then go to CHANGE. If cfg_mode is high, hold in DISPENSE with dispense_valid low until cfg_mode drops, because a config write would mask the update.
- CHANGE: one cycle. change_amount = credit − price (dispensed), or credit (refund/sold-out). Pulse change_valid only if the amount is non-zero. Clear credit and return to IDLE.
- Coins: accepted (coin_valid&&coin_ready) in every state except CHANGE. credit = min(credit+coin_value, 2^CUR_W−1), saturating with no wrap.
- cancel in IDLE with credit≠0: go to CHANGE and refund. With credit==0 it is ignored.
- A coin and cancel in the same COLLECT cycle: the coin is added before the refund, so the refund includes it.
- Price 0: dispense with no coins. Change equals any pre-inserted credit.
- Stock is checked only at LOOKUP. The item memory saturates the decrement itself.

## Timing
- Reset (rstn low at posedge): state IDLE. mem_raddr, dispense_index, change_amount, credit = 0. All pulses and busy = 0.
- Selection accepted at edge 0. mem_raddr is valid after edge 0, memory data is latched at edge 2, and COLLECT is entered at edge 2.
- With sufficient prior credit: DISPENSE is entered at edge 3, dispense_valid is high between edges 3 and 4, change_valid is high between edges 4 and 5, and IDLE is reached at edge 5.
- Credit ≥ price is evaluated on the registered credit. A coin that crosses the threshold at edge n gives DISPENSE at edge n+1.
- Reset mid-transaction discards credit with no refund pulse.

## Structure
- Package vend_pkg holds: state enum, CUR_W default, timeout width derivation, and an address-width function shared with the item memory.
- Sub-module vend_credit_acc contains the saturating credit register, the coin accept logic, and the timeout counter (clear/load controls from the FSM).
- The top level holds the FSM, the selection/price latch, and the output registers.

## Test plan
- Reset: rstn low 2 cycles with coin_valid high → credit=0, all pulses 0, sel_ready=1.
- Slot 5 price 150, avail 3. Coins 100, 100, then select 5 → dispense_valid at edge 3 with index 5, then change_valid with 50, credit 0.
- Select slot 7 with avail 0 after a 25 coin → sold_out pulse at edge 2, change_valid 25, no dispense_valid.
- Select price 200, coin 50, wait TIMEOUT_CYC with no coins → change_valid 50, back in IDLE.
- Credit 0xFFF0, coin 0x0100 → credit saturates at 0xFFFF. Coin and cancel in the same cycle → refund includes the coin.
- cfg_mode raised while entering DISPENSE → dispense_valid withheld until cfg_mode low, then exactly one pulse.
